cla_sub_pipe: RTL
=================

CLA_SUB_PIPE -- requirements
Module: cla_sub_pipe

Interface
REQ-001 SHALL have parameter m, default 16, operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand set A/B/Bin is valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand set this cycle.
REQ-006 SHALL have port A, input, m, minuend.
REQ-007 SHALL have port B, input, m, subtrahend.
REQ-008 SHALL have port Bin, input, 1, borrow-in.
REQ-009 SHALL have port out_valid, output, 1, Diff/Borrow/Ovf are valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port Diff, output, m, difference A-B-Bin modulo 2^m.
REQ-012 SHALL have port Borrow, output, 1, unsigned borrow-out (1 when A < B+Bin).
REQ-013 SHALL have port Ovf, output, 1, two's-complement signed overflow of the subtraction.

Function
REQ-014 SHALL compute A + ~B + ~Bin using carry-lookahead in 4-bit groups; Borrow = NOT carry-out; Ovf = carry into MSB XOR carry-out.
REQ-015 SHALL have two pipeline stages: S1 registers per-bit p/g and per-group P/G; S2 registers the group-carry resolution, Diff, Borrow and Ovf.
REQ-016 SHALL produce out_valid exactly 2 cycles after an accepted input when out_ready is held high (latency 2, throughput 1 per cycle).
REQ-017 SHALL transfer an input only when in_valid && in_ready, and an output only when out_valid && out_ready.
REQ-018 SHALL drive in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready; in_ready SHALL NOT depend on in_valid.
REQ-019 SHALL hold Diff/Borrow/Ovf and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, when stalled with both stages full, deassert in_ready and lose no data; on release, results SHALL emerge in acceptance order.
REQ-021 SHALL, on simultaneous output transfer and S1 advance, load S2 from S1 in the same cycle with no bubble.
REQ-022 SHALL treat Bin=1 with B=2^m-1 as a full wrap: Diff = A modulo 2^m, Borrow = 1.

Reset
REQ-023 SHALL, when rst is high at a clock edge, clear s1_valid and s2_valid and drive in_ready=1 in the following cycle, out_valid=0, Diff=0, Borrow=0, Ovf=0.
REQ-024 SHALL discard any in-flight operand sets when rst is asserted mid-operation; none SHALL appear after reset.
REQ-025 SHALL ignore in_valid during a cycle in which rst is high.

Configuration
REQ-026 SHALL, with macro CLA_SUB_SAT_EN defined, replace Diff on signed overflow with the saturated value (0x7FFF..F if A is non-negative, 0x8000..0 if A is negative); Ovf SHALL still report the overflow.
REQ-027 SHALL, without CLA_SUB_SAT_EN, output the wrapped modulo-2^m difference with no saturation logic present.

Structure
REQ-028 SHALL place GROUP_W=4, the group P/G record typedef and the saturation constant functions in shared package cla_pkg.
REQ-029 SHALL use one sub-module cla_group4, instantiated m/4 times, that produces group P/G and the internal carries from a 4-bit p/g and a carry-in.

Verification (m=16)
REQ-030 SHALL check A=0x0005, B=0x0003, Bin=0 -> after 2 cycles Diff=0x0002, Borrow=0, Ovf=0.
REQ-031 SHALL check A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Borrow=1, Ovf=0.
REQ-032 SHALL check A=0x8000, B=0x0001, Bin=0 -> Ovf=1; Diff=0x7FFF without the macro and 0x8000 with CLA_SUB_SAT_EN.
REQ-033 SHALL check streaming of 100 random sets with random out_ready stalls -> results match the reference model in order, with no drops or duplicates and stable outputs while stalled.
REQ-034 SHALL check rst asserted with both stages full -> next cycle out_valid=0, in_ready=1; neither flushed set is ever output.
REQ-035 SHALL check A=0x1234, B=0xFFFF, Bin=1 -> Diff=0x1234, Borrow=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor:
// group width, group propagate/generate record and the saturation limits.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic P;
        logic G;
    } grp_pg_t;

    // Group propagate/generate of one 4-bit slice of per-bit p/g.
    function automatic grp_pg_t grp_pg(input logic [GROUP_W-1:0] p,
                                       input logic [GROUP_W-1:0] g);
        grp_pg_t r;
        r.P = &p;
        r.G = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

    // Largest positive two's-complement value of width w (0x7F..F).
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width w (0x80..0).
    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: group P/G and the carry into each bit of
// the group from per-bit p/g and the group carry-in.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p_i,
    input  logic [GROUP_W-1:0] g_i,
    input  logic               c_i,
    output logic               P_o,
    output logic               G_o,
    output logic [GROUP_W-1:0] c_o
);

    grp_pg_t pg;

    assign pg  = grp_pg(p_i, g_i);
    assign P_o = pg.P;
    assign G_o = pg.G;

    // Lookahead carries: c_o[k] is the carry into bit k of the group.
    always_comb begin
        c_o[0] = c_i;
        c_o[1] = g_i[0] | (p_i[0] & c_i);
        c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
        c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & c_i);
    end

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined carry-lookahead subtractor, Diff = A - B - Bin.
// Computed as A + ~B + ~Bin; Borrow is the inverted carry-out.
// Stage 1 registers per-bit p/g and per-group P/G; stage 2 resolves the
// group carries and registers Diff/Borrow/Ovf. Valid/ready on both sides.
// Optional macro CLA_SUB_SAT_EN: saturate Diff on signed overflow.
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int m = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [m-1:0] A,
    input  logic [m-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [m-1:0] Diff,
    output logic         Borrow,
    output logic         Ovf
);

    localparam int NG = m / GROUP_W;

    logic              s1_valid_q;
    logic              s2_valid_q;
    logic              s1_adv;
    logic              in_fire;

    logic [m-1:0]      p_d, g_d, p_q, g_q;
    grp_pg_t [NG-1:0]  grp_d, grp_q;
    logic              cin_q;

    logic [NG:0]       cg;
    logic [m-1:0]      cbit;
    logic [NG-1:0]     grp_p_unused, grp_g_unused;
    logic [m-1:0]      raw_diff, diff_d, diff_q;
    logic              cout, ovf_d, borrow_q, ovf_q;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // Per-bit and per-group propagate/generate of A + ~B.
    always_comb begin
        p_d = A ^ ~B;
        g_d = A & ~B;
        for (int k = 0; k < NG; k++) begin
            grp_d[k] = grp_pg(p_d[k*GROUP_W +: GROUP_W], g_d[k*GROUP_W +: GROUP_W]);
        end
    end

    // Stage 1 occupancy; reset wins over any in_valid in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
    end

    // ---- stage 1 register boundary ----
    // Stage 1 data, loaded only on an accepted operand set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            p_q   <= p_d;
            g_q   <= g_d;
            grp_q <= grp_d;
            cin_q <= ~Bin;
        end
    end

`ifdef CLA_SUB_SAT_EN
    localparam logic [63:0] SAT_POS = sat_pos(m);
    localparam logic [63:0] SAT_NEG = sat_neg(m);

    logic a_neg_q;

    // Sign of A travels with the operand set to pick the saturation rail.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_neg_q <= A[m-1];
        end
    end

    function automatic logic [m-1:0] saturate(input logic [m-1:0] raw,
                                              input logic ovf,
                                              input logic a_neg);
        if (!ovf) begin
            return raw;
        end
        return a_neg ? SAT_NEG[m-1:0] : SAT_POS[m-1:0];
    endfunction
`endif

    // Group-level lookahead: carry into each 4-bit group.
    always_comb begin
        cg    = '0;
        cg[0] = cin_q;
        for (int k = 0; k < NG; k++) begin
            cg[k+1] = grp_q[k].G | (grp_q[k].P & cg[k]);
        end
    end

    // Group P/G from the instances duplicates the stage 1 registers; only
    // the per-bit carries are consumed here.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .p_i (p_q[k*GROUP_W +: GROUP_W]),
            .g_i (g_q[k*GROUP_W +: GROUP_W]),
            .c_i (cg[k]),
            .P_o (grp_p_unused[k]),
            .G_o (grp_g_unused[k]),
            .c_o (cbit[k*GROUP_W +: GROUP_W])
        );
    end

    assign raw_diff = p_q ^ cbit;
    assign cout     = cg[NG];
    assign ovf_d    = cbit[m-1] ^ cout;

`ifdef CLA_SUB_SAT_EN
    assign diff_d = saturate(raw_diff, ovf_d, a_neg_q);
`else
    assign diff_d = raw_diff;
`endif

    // ---- stage 2 register boundary ----
    // Stage 2 holds while the consumer stalls; refills from stage 1 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q   <= diff_d;
                borrow_q <= ~cout;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign Diff      = diff_q;
    assign Borrow    = borrow_q;
    assign Ovf       = ovf_q;

endmodule
